bram_program_loader: RTL and testbench

//  Upstream feeder of the instruction BRAM. Takes bytes from the UART receiver and assembles

---
 rtl/bram_program_loader_pkg.sv | 17 +
 rtl/bram_program_loader_word_assembler.sv | 41 ++++
 rtl/bram_program_loader.sv | 108 ++++++++++
 tb/tb_bram_program_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_program_loader_pkg.sv
// Shared constants for the instruction-BRAM program loader: default widths,
// the halt word and the FSM state encoding.
package bram_program_loader_pkg;

    localparam int          ADDRESS_BITS_DEF = 8;
    localparam int          DATA_BITS_DEF    = 32;
    localparam logic [31:0] END_WORD_DEF     = 32'hFFFF_FFFF;

    // Loader FSM states; the encoding is fixed so debug probes can decode it.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bram_program_loader_word_assembler.sv
// Shifts received bytes MSB-first into a DATA_BITS word and flags the strobe
// that carries the final byte of a word.
module bram_program_loader_word_assembler #(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic [7:0]           i_byte,
    output logic [DATA_BITS-1:0] o_word,
    output logic                 o_word_ready
);

    localparam int BYTES = DATA_BITS / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DATA_BITS-1:0] r_word;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_last;

    // The strobe currently presented completes a word.
    assign w_last       = (r_cnt == CNT_W'(BYTES - 1));
    assign o_word_ready = i_valid && w_last;
    assign o_word       = r_word;

    // Shift register and byte counter; clear restarts assembly from an empty word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_valid) begin
            r_word <= DATA_BITS'({r_word, i_byte});
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bram_program_loader.sv
// Loads a program received byte-by-byte from the UART into the instruction BRAM.
// Words are written to consecutive addresses from 0 until the halt word has been
// written or the last address has been filled.
//
// Handshake: i_rx_done is a one-cycle strobe qualifying i_rx_data; there is no
// back-pressure, so a byte is either consumed in that cycle or dropped.
// o_write_enable is a one-cycle strobe qualifying o_address/o_data.
module bram_program_loader
    import bram_program_loader_pkg::*;
#(
    parameter int                   ADDRESS_BITS = ADDRESS_BITS_DEF,
    parameter int                   DATA_BITS    = DATA_BITS_DEF,
    parameter logic [DATA_BITS-1:0] END_WORD     = DATA_BITS'(END_WORD_DEF)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_rx_done,
    input  logic [7:0]              i_rx_data,
    output logic                    o_write_enable,
    output logic [ADDRESS_BITS-1:0] o_address,
    output logic [DATA_BITS-1:0]    o_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_overflow
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDRESS_BITS-1:0] r_addr;
    logic                    r_overflow;
    logic [DATA_BITS-1:0]    w_word;
    logic                    w_word_ready;
    logic                    w_start;
    logic                    w_is_end;
    logic                    w_addr_last;
    logic                    w_write_exit;
    logic                    w_byte_ok;

    // A start is honoured only when no load is in progress.
    assign w_start      = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_is_end     = (w_word == END_WORD);
    assign w_addr_last  = (r_addr == {ADDRESS_BITS{1'b1}});
    assign w_write_exit = (r_state == S_WRITE) && (w_is_end || w_addr_last);
    // Bytes count in LOAD, and in WRITE unless that write finishes the load.
    assign w_byte_ok    = i_rx_done &&
                          ((r_state == S_LOAD) || ((r_state == S_WRITE) && !w_write_exit));

    bram_program_loader_word_assembler #(
        .DATA_BITS (DATA_BITS)
    ) u_assembler (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start),
        .i_valid      (w_byte_ok),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_LOAD;
            S_LOAD:  if (w_word_ready) w_next_state = S_WRITE;
            S_WRITE: begin
                if (w_write_exit)      w_next_state = S_DONE;
                else if (w_word_ready) w_next_state = S_WRITE;
                else                   w_next_state = S_LOAD;
            end
            S_DONE:  if (w_start) w_next_state = S_LOAD;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Address counter and overflow flag; the address never wraps past the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_overflow <= 1'b0;
        end else if (w_start) begin
            r_addr     <= '0;
            r_overflow <= 1'b0;
        end else if (r_state == S_WRITE) begin
            if (w_write_exit) r_overflow <= !w_is_end;
            else              r_addr     <= r_addr + 1'b1;
        end
    end

    // Status and write strobe decoded from state.
    always_comb begin
        o_write_enable = (r_state == S_WRITE);
        o_busy         = (r_state == S_LOAD) || (r_state == S_WRITE);
        o_done         = (r_state == S_DONE);
    end

    assign o_address  = r_addr;
    assign o_data     = w_word;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_bram_program_loader.sv
// Directed bench for bram_program_loader: a default-size instance and a
// 4-word instance for the address-exhaustion case.
module tb_bram_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_rx_done;
    logic [7:0]  i_rx_data;
    logic        o_write_enable, o_busy, o_done, o_overflow;
    logic [7:0]  o_address;
    logic [31:0] o_data;

    logic        s_start, s_rx_done;
    logic [7:0]  s_rx_data;
    logic        s_write_enable, s_busy, s_done, s_overflow;
    logic [1:0]  s_address;
    logic [31:0] s_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [1:0]  sa_q[$];
    logic [31:0] sd_q[$];
    logic [7:0]  exp_a[$];
    logic [31:0] exp_d[$];

    bram_program_loader dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_rx_done      (i_rx_done),
        .i_rx_data      (i_rx_data),
        .o_write_enable (o_write_enable),
        .o_address      (o_address),
        .o_data         (o_data),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_overflow     (o_overflow)
    );

    bram_program_loader #(.ADDRESS_BITS(2)) dut_small (
        .clk            (clk),
        .rst            (rst),
        .i_start        (s_start),
        .i_rx_done      (s_rx_done),
        .i_rx_data      (s_rx_data),
        .o_write_enable (s_write_enable),
        .o_address      (s_address),
        .o_data         (s_data),
        .o_busy         (s_busy),
        .o_done         (s_done),
        .o_overflow     (s_overflow)
    );

    // Clock.
    always #5 clk = ~clk;

    // Record every BRAM write, sampled away from the active edge.
    always @(negedge clk) begin
        if (o_write_enable === 1'b1) begin
            wa_q.push_back(o_address);
            wd_q.push_back(o_data);
        end
        if (s_write_enable === 1'b1) begin
            sa_q.push_back(s_address);
            sd_q.push_back(s_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_start = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
        s_start = 1'b0; s_rx_done = 1'b0; s_rx_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();
        wa_q.delete(); wd_q.delete(); sa_q.delete(); sd_q.delete();
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_done = 1'b1;
        i_rx_data = b;
        tick();
        i_rx_done = 1'b0;
    endtask

    // Four bytes MSB-first, each followed by an idle cycle.
    task automatic send_word_gap(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[8*k +: 8]);
            tick();
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (o_done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (o_done !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_done: o_done=%b after %0d cycles, required 1", o_done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_start = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
        s_start = 1'b0; s_rx_done = 1'b0; s_rx_data = 8'h00;
        tick();
        vectors++; if (o_write_enable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b required 0", o_write_enable); end
        vectors++; if (o_address !== 8'h00) begin miscompares++; $display("FAIL reset_addr: got %h required 00", o_address); end
        vectors++; if (o_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h required 0", o_data); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", o_busy); end
        vectors++; if (o_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b required 0", o_done); end
        vectors++; if (o_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b required 0", o_overflow); end
        vectors++; if (s_done !== 1'b0 || s_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_small: done=%b ovf=%b required 0 0", s_done, s_overflow); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        pulse_start();
        vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL halt_busy: got %b required 1", o_busy); end
        send_word_gap(32'h1234_5678);
        send_word_gap(32'hFFFF_FFFF);
        wait_done();
        exp_a = {8'd0, 8'd1};
        exp_d = {32'h1234_5678, 32'hFFFF_FFFF};
        vectors++; if (wa_q.size() != exp_a.size()) begin miscompares++; $display("FAIL halt_count: got %0d writes required %0d", wa_q.size(), exp_a.size()); end
        for (int k = 0; k < exp_a.size(); k++) begin
            vectors++;
            if (k >= wa_q.size()) begin miscompares++; $display("FAIL halt_write%0d: missing, required %h@%h", k, exp_d[k], exp_a[k]); end
            else if (wa_q[k] !== exp_a[k] || wd_q[k] !== exp_d[k]) begin miscompares++; $display("FAIL halt_write%0d: got %h@%h required %h@%h", k, wd_q[k], wa_q[k], exp_d[k], exp_a[k]); end
        end
        vectors++; if (o_overflow !== 1'b0) begin miscompares++; $display("FAIL halt_ovf: got %b required 0", o_overflow); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL halt_busy_done: got %b required 0", o_busy); end
        vectors++; if (o_address !== 8'd1) begin miscompares++; $display("FAIL halt_addr_hold: got %h required 01", o_address); end
    endtask

    task automatic test_overflow();
        int n = 0;
        do_reset();
        s_start = 1'b1; tick(); s_start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            s_rx_done = 1'b1; s_rx_data = 8'(k); tick();
        end
        s_rx_done = 1'b0;
        while (s_done !== 1'b1 && n < 50) begin tick(); n++; end
        vectors++; if (s_done !== 1'b1) begin miscompares++; $display("FAIL ovf_done: got %b required 1", s_done); end
        vectors++; if (s_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b required 1", s_overflow); end
        vectors++; if (s_address !== 2'd3) begin miscompares++; $display("FAIL ovf_addr: got %h required 3", s_address); end
        // Further bytes after exhaustion must not produce writes.
        for (int k = 0; k < 4; k++) begin s_rx_done = 1'b1; s_rx_data = 8'hA0; tick(); end
        s_rx_done = 1'b0;
        repeat (3) tick();
        exp_d = {32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};
        vectors++; if (sa_q.size() != 4) begin miscompares++; $display("FAIL ovf_count: got %0d writes required 4", sa_q.size()); end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= sa_q.size()) begin miscompares++; $display("FAIL ovf_write%0d: missing, required %h@%0d", k, exp_d[k], k); end
            else if (sa_q[k] !== 2'(k) || sd_q[k] !== exp_d[k]) begin miscompares++; $display("FAIL ovf_write%0d: got %h@%h required %h@%0d", k, sd_q[k], sa_q[k], exp_d[k], k); end
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        pulse_start();
        send_word_gap(32'h0102_0304);
        send_byte(8'hA1);
        tick();
        send_byte(8'hA2);
        #2 rst = 1'b1;
        #1;
        vectors++; if (o_busy !== 1'b0 || o_write_enable !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy_we: got %b %b required 0 0", o_busy, o_write_enable); end
        vectors++; if (o_address !== 8'h00) begin miscompares++; $display("FAIL rstmid_addr: got %h required 00", o_address); end
        vectors++; if (o_data !== 32'h0) begin miscompares++; $display("FAIL rstmid_data: got %h required 0", o_data); end
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        send_word_gap(32'hAABB_CCDD);
        repeat (2) tick();
        exp_a = {8'd0, 8'd0};
        exp_d = {32'h0102_0304, 32'hAABB_CCDD};
        vectors++; if (wa_q.size() != exp_a.size()) begin miscompares++; $display("FAIL rstmid_count: got %0d writes required %0d", wa_q.size(), exp_a.size()); end
        for (int k = 0; k < exp_a.size(); k++) begin
            vectors++;
            if (k >= wa_q.size()) begin miscompares++; $display("FAIL rstmid_write%0d: missing, required %h@%h", k, exp_d[k], exp_a[k]); end
            else if (wa_q[k] !== exp_a[k] || wd_q[k] !== exp_d[k]) begin miscompares++; $display("FAIL rstmid_write%0d: got %h@%h required %h@%h", k, wd_q[k], wa_q[k], exp_d[k], exp_a[k]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse_start();
        // 0x11 lands in the WRITE cycle of word 0.
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_byte(8'h11);
        tick();
        send_byte(8'h22); tick(); send_byte(8'h33); tick(); send_byte(8'h44); tick();
        send_word_gap(32'hFFFF_FFFF);
        wait_done();
        exp_a = {8'd0, 8'd1, 8'd2};
        exp_d = {32'hAABB_CCDD, 32'h1122_3344, 32'hFFFF_FFFF};
        vectors++; if (wa_q.size() != exp_a.size()) begin miscompares++; $display("FAIL b2b_count: got %0d writes required %0d", wa_q.size(), exp_a.size()); end
        for (int k = 0; k < exp_a.size(); k++) begin
            vectors++;
            if (k >= wa_q.size()) begin miscompares++; $display("FAIL b2b_write%0d: missing, required %h@%h", k, exp_d[k], exp_a[k]); end
            else if (wa_q[k] !== exp_a[k] || wd_q[k] !== exp_d[k]) begin miscompares++; $display("FAIL b2b_write%0d: got %h@%h required %h@%h", k, wd_q[k], wa_q[k], exp_d[k], exp_a[k]); end
        end
    endtask

    task automatic test_ignored();
        do_reset();
        // Bytes while IDLE.
        send_word_gap(32'h5566_7788);
        vectors++; if (wa_q.size() != 0 || o_busy !== 1'b0) begin miscompares++; $display("FAIL idle_ignore: got %0d writes busy=%b required 0 0", wa_q.size(), o_busy); end
        pulse_start();
        send_word_gap(32'h0102_0304);
        pulse_start();
        send_word_gap(32'h0506_0708);
        send_word_gap(32'hFFFF_FFFF);
        wait_done();
        // Bytes while DONE.
        send_word_gap(32'h0000_0000);
        vectors++; if (o_done !== 1'b1 || o_address !== 8'd2) begin miscompares++; $display("FAIL done_hold: got done=%b addr=%h required 1 02", o_done, o_address); end
        exp_a = {8'd0, 8'd1, 8'd2};
        exp_d = {32'h0102_0304, 32'h0506_0708, 32'hFFFF_FFFF};
        vectors++; if (wa_q.size() != exp_a.size()) begin miscompares++; $display("FAIL ign_count: got %0d writes required %0d", wa_q.size(), exp_a.size()); end
        for (int k = 0; k < exp_a.size(); k++) begin
            vectors++;
            if (k >= wa_q.size()) begin miscompares++; $display("FAIL ign_write%0d: missing, required %h@%h", k, exp_d[k], exp_a[k]); end
            else if (wa_q[k] !== exp_a[k] || wd_q[k] !== exp_d[k]) begin miscompares++; $display("FAIL ign_write%0d: got %h@%h required %h@%h", k, wd_q[k], wa_q[k], exp_d[k], exp_a[k]); end
        end
    endtask

    task automatic test_reload();
        // Small instance is still DONE with overflow from test_overflow.
        s_start = 1'b1; tick(); s_start = 1'b0;
        vectors++; if (s_done !== 1'b0 || s_overflow !== 1'b0 || s_busy !== 1'b1) begin miscompares++; $display("FAIL reload_small: got done=%b ovf=%b busy=%b required 0 0 1", s_done, s_overflow, s_busy); end
        do_reset();
        pulse_start();
        send_word_gap(32'h1111_2222);
        send_word_gap(32'hFFFF_FFFF);
        wait_done();
        wa_q.delete(); wd_q.delete();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        vectors++; if (o_done !== 1'b0 || o_busy !== 1'b1) begin miscompares++; $display("FAIL reload_done_drop: got done=%b busy=%b required 0 1", o_done, o_busy); end
        vectors++; if (o_address !== 8'd0) begin miscompares++; $display("FAIL reload_addr: got %h required 00", o_address); end
        send_word_gap(32'h0BAD_F00D);
        send_word_gap(32'hFFFF_FFFF);
        wait_done();
        exp_a = {8'd0, 8'd1};
        exp_d = {32'h0BAD_F00D, 32'hFFFF_FFFF};
        vectors++; if (wa_q.size() != exp_a.size()) begin miscompares++; $display("FAIL reload_count: got %0d writes required %0d", wa_q.size(), exp_a.size()); end
        for (int k = 0; k < exp_a.size(); k++) begin
            vectors++;
            if (k >= wa_q.size()) begin miscompares++; $display("FAIL reload_write%0d: missing, required %h@%h", k, exp_d[k], exp_a[k]); end
            else if (wa_q[k] !== exp_a[k] || wd_q[k] !== exp_d[k]) begin miscompares++; $display("FAIL reload_write%0d: got %h@%h required %h@%h", k, wd_q[k], wa_q[k], exp_d[k], exp_a[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_overflow();
        test_reload();
        test_reset_mid_load();
        test_back_to_back();
        test_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
